// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared state encodings and framing constants for the UART program loader
package uart_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} loader_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: imem write bus plus loader status (master drives, slave observes)
interface uart_program_loader_if #(parameter int ADDR_W = 10);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_reset;
  logic              program_receiving;
  logic              program_done;
  logic              program_ov;
  logic              frame_err;
  logic [7:0]        program_csum;
  modport master (output mem_we, mem_addr, mem_wdata, core_reset, program_receiving, program_done, program_ov, frame_err, program_csum);
  modport slave (input mem_we, mem_addr, mem_wdata, core_reset, program_receiving, program_done, program_ov, frame_err, program_csum);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver (rx in; byte_valid/byte_data/sticky frame_err out), mid-bit sampling every CLK_DIV cycles
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLK_DIV = 1085
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  rx_state_e st_q, st_d;
  logic s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic bv_q, bv_d, fe_q, fe_d;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {s1_q, s2_q, prev_q} <= 3'b111;
      st_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      bv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      {s1_q, s2_q, prev_q} <= {rx, s1_q, s2_q};
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      bv_q <= bv_d;
      fe_q <= fe_d;
    end
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    bv_d = 1'b0;
    fe_d = fe_q;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d = s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'(UART_DATA_BITS - 1)) st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL) begin
        bv_d = s2_q;
        fe_d = fe_q | !s2_q;
        st_d = s2_q ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (s2_q) st_d = RX_IDLE;
      default: st_d = RX_IDLE;
    endcase
  end
  assign byte_valid = bv_q;
  assign byte_data = sh_q;
  assign frame_err = fe_q;
endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader: UART boot loader (clock/reset/rx in, imem bus + status out via interface) packing bytes into words; UART_LOADER_CSUM_EN enables checksum + verify token
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_DIV        = 1085,
  parameter int PROG_BYTES     = 4096,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  uart_program_loader_if.master bus
);
  localparam int NW = $clog2(PROG_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  loader_state_e st_q, st_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [31:0] word_q, word_d, wdata_q, wdata_d, packed_w;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] csum_q, csum_d, byte_data;
  logic ov_q, ov_d, recv_q, recv_d, we_q, we_d;
  logic byte_valid, frame_err, accept;
  logic [1:0] lane;
  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );
  assign lane = 2'(cnt_q);
  assign accept = byte_valid && (st_q == IDLE || st_q == LOAD);
  assign packed_w = word_q | (32'(byte_data) << {lane, 3'b000});
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      cnt_q <= '0;
      word_q <= '0;
      addr_q <= '0;
      tmo_q <= '0;
      csum_q <= '0;
      ov_q <= 1'b0;
      recv_q <= 1'b0;
      we_q <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      addr_q <= addr_d;
      tmo_q <= tmo_d;
      csum_q <= csum_d;
      ov_q <= ov_d;
      recv_q <= recv_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    word_d = word_q;
    addr_d = addr_q;
    tmo_d = '0;
    csum_d = csum_q;
    ov_d = ov_q;
    recv_d = 1'b0;
    we_d = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      word_d = packed_w;
      recv_d = 1'b1;
`ifdef UART_LOADER_CSUM_EN
      csum_d = csum_q ^ byte_data;
`endif
      if (lane == 2'(BYTES_PER_WORD - 1)) begin
        we_d = 1'b1;
        wdata_d = packed_w;
        waddr_d = addr_q;
        addr_d = addr_q + 1'b1;
        word_d = '0;
      end
      st_d = (cnt_d == NW'(PROG_BYTES)) ? FLUSH : LOAD;
    end else if (st_q == LOAD) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_d == TW'(TIMEOUT_CYCLES)) st_d = FLUSH;
    end else if (st_q == FLUSH) begin
      we_d = lane != 2'd0;
      wdata_d = word_q;
      waddr_d = addr_q;
      st_d = DONE;
    end else if (st_q == DONE && byte_valid) begin
`ifdef UART_LOADER_CSUM_EN
      recv_d = byte_data == csum_q;
      ov_d = ov_q | (byte_data != csum_q);
`else
      ov_d = 1'b1;
`endif
    end
  end
  assign bus.mem_we = we_q;
  assign bus.mem_addr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.core_reset = st_q != DONE;
  assign bus.program_receiving = recv_q;
  assign bus.program_done = st_q == DONE;
  assign bus.program_ov = ov_q;
  assign bus.frame_err = frame_err;
  assign bus.program_csum = csum_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed self-checking bench for uart_program_loader
module tb_uart_program_loader;
  localparam int CLK_DIV = 16;
  localparam int PROG_BYTES = 8;
  localparam int ADDR_W = 10;
  localparam int TIMEOUT_CYCLES = 2000;
`ifdef UART_LOADER_CSUM_EN
  localparam logic [7:0] CSUM_EXP = 8'h88;
`else
  localparam logic [7:0] CSUM_EXP = 8'h00;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int wr_n = 0;
  int recv_n = 0;
  logic [31:0] wr_a [64];
  logic [31:0] wr_d [64];
  uart_program_loader_if #(.ADDR_W(ADDR_W)) bus ();
  uart_program_loader #(
    .CLK_DIV(CLK_DIV),
    .PROG_BYTES(PROG_BYTES),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .bus(bus)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (bus.mem_we && wr_n < 64) begin
      wr_a[wr_n] = 32'(bus.mem_addr);
      wr_d[wr_n] = bus.mem_wdata;
      wr_n++;
    end
    if (bus.program_receiving) recv_n++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(3);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CLK_DIV);
    end
    rx = stop;
    idle(CLK_DIV);
    rx = 1'b1;
    idle(4);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 32'(bus.core_reset), 32'd1);
    check({tag, "_done"}, 32'(bus.program_done), 32'd0);
    check({tag, "_ov"}, 32'(bus.program_ov), 32'd0);
    check({tag, "_ferr"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_csum"}, 32'(bus.program_csum), 32'd0);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
  endtask
  task automatic send_image(input int base);
    for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)), 1'b1);
    idle(4);
    check("img_nwrites", 32'(wr_n - base), 32'd2);
    check("img_a0", wr_a[base], 32'd0);
    check("img_d0", wr_d[base], 32'h44332211);
    check("img_a1", wr_a[base+1], 32'd1);
    check("img_d1", wr_d[base+1], 32'h88776655);
    check("img_done", 32'(bus.program_done), 32'd1);
    check("img_core_reset", 32'(bus.core_reset), 32'd0);
  endtask
  initial begin
    int base, r0;
    do_reset();
    check_reset_vals("rst");
    base = wr_n;
    r0 = recv_n;
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h11 * (i + 1)), 1'b1);
      check("recv_pulse", 32'(recv_n - r0), 32'(i + 1));
    end
    idle(4);
    check("full_nwrites", 32'(wr_n - base), 32'd2);
    check("full_a0", wr_a[base], 32'd0);
    check("full_d0", wr_d[base], 32'h44332211);
    check("full_a1", wr_a[base+1], 32'd1);
    check("full_d1", wr_d[base+1], 32'h88776655);
    check("full_done", 32'(bus.program_done), 32'd1);
    check("full_core_reset", 32'(bus.core_reset), 32'd0);
    check("full_csum", 32'(bus.program_csum), 32'(CSUM_EXP));
    base = wr_n;
    r0 = recv_n;
`ifdef UART_LOADER_CSUM_EN
    send(8'h88, 1'b1);
    check("verify_ov", 32'(bus.program_ov), 32'd0);
    check("verify_recv", 32'(recv_n - r0), 32'd1);
    r0 = recv_n;
`endif
    send(8'hBA, 1'b1);
    check("ov_set", 32'(bus.program_ov), 32'd1);
    check("ov_nowrite", 32'(wr_n - base), 32'd0);
    check("ov_norecv", 32'(recv_n - r0), 32'd0);
    do_reset();
    base = wr_n;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    reset = 1'b1;
    idle(2);
    check_reset_vals("midrst");
    check("midrst_nowrite", 32'(wr_n - base), 32'd0);
    reset = 1'b0;
    idle(3);
    send_image(wr_n);
    do_reset();
    base = wr_n;
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b1);
    check("tmo_pre_done", 32'(bus.program_done), 32'd0);
    check("tmo_pre_core_reset", 32'(bus.core_reset), 32'd1);
    check("tmo_pre_nwrites", 32'(wr_n - base), 32'd1);
    idle(TIMEOUT_CYCLES + 50);
    check("tmo_nwrites", 32'(wr_n - base), 32'd2);
    check("tmo_a0", wr_a[base], 32'd0);
    check("tmo_d0", wr_d[base], 32'hA3A2A1A0);
    check("tmo_a1", wr_a[base+1], 32'd1);
    check("tmo_d1", wr_d[base+1], 32'h000000A4);
    check("tmo_done", 32'(bus.program_done), 32'd1);
    do_reset();
    base = wr_n;
    r0 = recv_n;
    send(8'h77, 1'b0);
    idle(10);
    check("ferr_set", 32'(bus.frame_err), 32'd1);
    check("ferr_norecv", 32'(recv_n - r0), 32'd0);
    for (int i = 0; i < 4; i++) send(8'(8'h5A + i), 1'b1);
    idle(4);
    check("ferr_nwrites", 32'(wr_n - base), 32'd1);
    check("ferr_a0", wr_a[base], 32'd0);
    check("ferr_d0", wr_d[base], 32'h5D5C5B5A);
    do_reset();
    r0 = recv_n;
    rx = 1'b0;
    idle(CLK_DIV / 2);
    rx = 1'b1;
    idle(40);
    check("glitch_norecv", 32'(recv_n - r0), 32'd0);
    check("glitch_noferr", 32'(bus.frame_err), 32'd0);
    send(8'h12, 1'b1);
    check("glitch_recover", 32'(recv_n - r0), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time program loader inside the FPGA top: deserializes bytes arriving on the board UART RX line and packs them little-endian into 32-bit words. It writes those words sequentially into the core's instruction memory and holds the core in reset until the image is complete. It also reports progress, completion and overflow to the host and to top-level pins (`program_receiving`, `program_done`, `program_ov`).

## Interface
- `CLK_DIV`, 1085: clock cycles per UART bit; 125 MHz / 115200 baud; minimum 8.
- `PROG_BYTES`, 4096: image size in bytes; reaching it ends the load.
- `ADDR_W`, 10: word-address width; 2^ADDR_W*4 ≥ PROG_BYTES.
- `TIMEOUT_CYCLES`, 2^20: line-idle cycles after ≥1 byte that end the load early.
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `rx` in 1: UART serial input, idle high, 8N1, LSB first.
- `mem_we` out 1: one-cycle word write strobe.
- `mem_addr` out ADDR_W: word address, starting at 0.
- `mem_wdata` out 32: packed word; byte 0 in [7:0].
- `core_reset` out 1: high until load complete.
- `program_receiving` out 1: one-cycle pulse per accepted byte; host paces the next byte on its rising edge.
- `program_done` out 1: sticky once load complete.
- `program_ov` out 1: sticky; a byte arrived after done.
- `frame_err` out 1: sticky; a stop bit sampled 0.
- `program_csum` out 8: running XOR of accepted bytes.

## Operation
- Reset values: all outputs 0 except `core_reset` = 1. Byte count, word buffer, address and timeout counter are cleared.
- RX path:
  - 2-flop synchronizer on `rx`.
  - A high→low edge while idle starts a frame. Start bit is re-checked at CLK_DIV/2; if high, the frame is a glitch and is dropped.
  - 8 data bits and the stop bit are sampled at mid-bit, every CLK_DIV cycles.
  - Stop = 1 → `byte_valid` for 1 cycle. Stop = 0 → byte discarded, `frame_err` set, receiver waits for line high before re-arming.
- Loader FSM, states IDLE, LOAD, FLUSH, DONE:
  - IDLE: first `byte_valid` → LOAD. The timeout counter is inactive in IDLE.
  - LOAD: each byte goes into lane (count mod 4), count increments, `program_receiving` pulses.
  - LOAD, word write: lane 3 filled → `mem_we` with the full word at `mem_addr`, then `mem_addr` increments.
  - LOAD → FLUSH: count == PROG_BYTES, or the timeout counter (cleared on each byte) reaches TIMEOUT_CYCLES.
  - FLUSH: if count mod 4 ≠ 0, write one partial word with unfilled lanes = 0x00; otherwise no write. Then → DONE.
  - DONE: `program_done` = 1, `core_reset` = 0. Every further `byte_valid` sets `program_ov`; no write, no `program_receiving`.
- `program_csum`: XOR over LOAD-accepted bytes only.
- Reset mid-load: everything returns to reset values; the next load restarts at address 0.

## Timing
- `byte_valid`: the cycle after the stop-bit sample.
- `program_receiving`: the cycle after `byte_valid`.
- `mem_we`: same cycle as the `program_receiving` pulse for lane 3. `mem_addr` and `mem_wdata` are valid only while `mem_we` = 1.
- Full-image end: the PROG_BYTES-th byte's write and the transition to FLUSH occur together. FLUSH lasts 1 cycle. `program_done` and `core_reset` deassertion follow 1 cycle after FLUSH.
- Timeout end: counter hits TIMEOUT_CYCLES → FLUSH next cycle, DONE one cycle later.
- Simultaneous byte and timeout: the byte wins, and the counter clears.
- Sampling tolerance: ±CLK_DIV/2 cycles of drift per frame.

## Configuration
- `UART_LOADER_CSUM_EN`
- Defined: `program_csum` is live. In DONE, a byte equal to the final checksum is accepted as a verify token: it does not set `program_ov`, and it produces one `program_receiving` pulse.
- Undefined: `program_csum` is tied to 0, and every post-done byte sets `program_ov`.

## Structure
- Package `uart_loader_pkg`:
  - `loader_state_e` (IDLE, LOAD, FLUSH, DONE)
  - `rx_state_e` (RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH)
  - `UART_DATA_BITS` = 8
  - `BYTES_PER_WORD` = 4
- Sub-module `uart_rx_byte`: synchronizer plus bit FSM. Parameter CLK_DIV; outputs `byte_valid`, `byte_data[7:0]`, `frame_err`.
- Top module: loader FSM, packing, counters.

## Test plan
All scenarios use CLK_DIV=16, PROG_BYTES=8, TIMEOUT_CYCLES=2000.
- Send 8 bytes 0x11..0x88, each paced on `program_receiving` → writes 0x44332211 @0 and 0x88776655 @1; `program_done`=1; `core_reset`=0; `program_csum`=0x88.
- Send 5 bytes 0xA0..0xA4, then idle 2000 cycles → writes 0xA3A2A1A0 @0 and 0x000000A4 @1 (FLUSH), then `program_done`.
- Send a 9th byte 0xBA after done → `program_ov`=1, no `mem_we`. With CSUM_EN, sending byte = final checksum instead → `program_ov` stays 0.
- Frame with stop bit 0 → `frame_err`=1, byte dropped, count unchanged; next good byte lands in lane 0.
- Assert `reset` after 3 bytes → all outputs at reset values; full 8-byte resend writes from address 0.
- 0.5-bit-wide low glitch on idle line → no `byte_valid`, no `frame_err`.
